// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the 2R1W register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef logic [WIDTH_DEF-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clr_fsm
//  Description : Bulk-clear sequencer; walks entries 1..DEPTH-1, one per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
import regfile_pkg::*;

module regfile_clr_fsm #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] c_first = AW'(1);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Entry 0 is never written, so the sweep starts at 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_we      = 1'b0;
        clr_addr    = r_cnt;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = c_first;
                end
            end
            CLEAR: begin
                clr_we    = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (r_state == CLEAR);

endmodule
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_2r1w
//  Description : 32x32 register file, 1 write / 2 registered reads, entry 0
//                hardwired to zero, sequenced bulk clear.
//                Optional macro REGFILE_BYPASS_EN: write-through forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
import regfile_pkg::*;

module reg_file_2r1w #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;

    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_wr_ok;
    logic             w_fwd_a;
    logic             w_fwd_b;

    regfile_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_wr_ok = we && !busy && (waddr != '0);

`ifdef REGFILE_BYPASS_EN
    assign w_fwd_a = w_wr_ok && (raddr_a == waddr);
    assign w_fwd_b = w_wr_ok && (raddr_b == waddr);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    // User writes and clear writes are exclusive: user writes need busy=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_rdata_a <= w_fwd_a ? wdata : r_mem[raddr_a];
            r_rdata_b <= w_fwd_b ? wdata : r_mem[raddr_b];
            if (w_wr_ok) begin
                r_mem[waddr] <= wdata;
            end
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_2r1w
//  Description : Self-checking bench for reg_file_2r1w (vectors, sequences,
//                randomized traffic against a behavioural model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        clr_req;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: array contents plus number of clear steps remaining.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_clr_left;

    always #5 clk = ~clk;

    reg_file_2r1w dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .clr_req (clr_req),
        .busy    (busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] c_raw = 32'd40;
`else
    localparam logic [31:0] c_raw = 32'd10;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic c);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; clr_req = c;
    endtask

    // Advance one clock: predict from current inputs, then compare after the edge.
    task automatic tick();
        bit wr;
        if (!rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_a = '0;
            m_b = '0;
            m_clr_left = 0;
        end else begin
            wr  = we && (m_clr_left == 0) && (waddr != 0);
            m_a = m_mem[raddr_a];
            m_b = m_mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
            if (wr && raddr_a == waddr) m_a = wdata;
            if (wr && raddr_b == waddr) m_b = wdata;
`endif
            if (wr) m_mem[waddr] = wdata;
            if (m_clr_left > 0) begin
                m_mem[DEPTH - m_clr_left] = '0;
                m_clr_left--;
            end else if (clr_req) begin
                m_clr_left = DEPTH - 1;
            end
        end
        @(posedge clk);
        #1;
        chk("model rdata_a", rdata_a, m_a);
        chk("model rdata_b", rdata_b, m_b);
        chk("model busy", {31'd0, busy}, {31'd0, m_clr_left > 0});
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(DEPTH - 1 - i), 1'b0);
            tick();
            if (i > 0) begin
                chk({name, " rdata_a"}, rdata_a, 32'd0);
                chk({name, " rdata_b"}, rdata_b, 32'd0);
            end
        end
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk({name, " last rdata_a"}, rdata_a, 32'd0);
        chk({name, " last rdata_b"}, rdata_b, 32'd0);
    endtask

    // Fill 1..31 with 10*i, pulse clr_req, count busy cycles; optional
    // discarded write mid-clear and optional reset on the given busy cycle.
    task automatic clear_run(input int rst_at, input string name);
        int n;
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b1, 5'(i), 32'(10 * i), 5'd0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd20, 5'd31, 1'b1);
        tick();
        chk({name, " busy rises"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (rst_at != 0 && n == rst_at) begin
                rst = 1'b0;
                drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
                tick();
                chk({name, " busy after reset"}, {31'd0, busy}, 32'd0);
                rst = 1'b1;
            end else if (n == 10) begin
                drive(1'b1, 5'd4, 32'd99, 5'd20, 5'd31, 1'b1);
                tick();
            end else begin
                drive(1'b0, 5'd0, 32'd0, 5'(n), 5'd31, 1'b0);
                tick();
            end
        end
        if (rst_at == 0) begin
            chk({name, " busy cycles"}, 32'(n), 32'd31);
            drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0);
            tick();
            chk({name, " discarded write"}, rdata_a, 32'd0);
        end else begin
            chk({name, " aborted at"}, 32'(n), 32'(rst_at));
        end
        read_all_zero({name, " post"});
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 5'd3,  32'd10,         5'd0,  5'd0,  32'd0,  32'd0};
        vecs[1] = '{1'b1, 5'd7,  32'd20,         5'd3,  5'd3,  32'd10, 32'd10};
        vecs[2] = '{1'b1, 5'd31, 32'd30,         5'd3,  5'd7,  32'd10, 32'd20};
        vecs[3] = '{1'b1, 5'd5,  32'd10,         5'd31, 5'd7,  32'd30, 32'd20};
        vecs[4] = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd0,  32'd0,  32'd0};
        vecs[5] = '{1'b0, 5'd0,  32'd0,          5'd0,  5'd0,  32'd0,  32'd0};
        vecs[6] = '{1'b0, 5'd0,  32'd0,          5'd3,  5'd31, 32'd10, 32'd30};
        vecs[7] = '{1'b1, 5'd5,  32'd40,         5'd5,  5'd5,  c_raw,  c_raw};
        vecs[8] = '{1'b0, 5'd0,  32'd0,          5'd5,  5'd3,  32'd40, 32'd10};

        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        read_all_zero("reset");

        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].ra, vecs[k].rb, 1'b0);
            tick();
            chk($sformatf("vec%0d rdata_a", k), rdata_a, vecs[k].ea);
            chk($sformatf("vec%0d rdata_b", k), rdata_b, vecs[k].eb);
        end

        // clr_req alongside a valid write: the write lands, then is wiped.
        drive(1'b1, 5'd9, 32'd77, 5'd9, 5'd0, 1'b1);
        tick();
        chk("wr+clr busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 40 && busy; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b0);
        tick();
        chk("wr+clr wiped", rdata_a, 32'd0);

        clear_run(0, "clear");
        clear_run(10, "midrst");
        clear_run(0, "reclear");

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 1'($urandom_range(0, 59) == 0));
            if ($urandom_range(0, 7) == 0) raddr_a = waddr;
            if ($urandom_range(0, 7) == 0) raddr_b = waddr;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32-entry x 32-bit register file, one write port and two read ports (A, B). It is the storage stage directly downstream of the single 32-bit load register: that register's captured word feeds the write port here.
- Reads are registered. Entry 0 is hardwired to zero.
- A sequenced bulk-clear engine zeroes the array one entry per cycle on request, and reports busy while running.

Parameters:
- WIDTH, 32, data width of each entry
- DEPTH, 32, number of entries
- AW, 5, address width; must equal clog2(DEPTH)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read address, port A
- raddr_b  in  AW  read address, port B
- rdata_a  out  WIDTH  registered read data, port A
- rdata_b  out  WIDTH  registered read data, port B
- clr_req  in  1  single-cycle pulse that requests a bulk clear
- busy  out  1  high while the clear engine runs; writes are discarded while high

Behaviour:
- Reset (rst=0 at a clk edge):
  - all entries go to 0
  - rdata_a=0, rdata_b=0, busy=0
  - FSM goes to IDLE, clear counter goes to 0
  - reset overrides every other input in that cycle
- Write:
  - when we=1, busy=0 and waddr!=0, entry[waddr] <= wdata at the edge
  - writes to address 0 are dropped; entry 0 always reads 0
- Read:
  - each edge, rdata_x <= entry[raddr_x], using the array value before any write at that same edge
  - one-cycle latency
  - both ports are independent and may use the same address
- Read-after-write, same address, same cycle: returns the old value. The new value is returned for a read issued one cycle later.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1. Counter loads 1 (entry 0 is already zero). busy rises at the next edge.
  - In CLEAR, each edge zeroes entry[counter], then counter increments.
  - CLEAR -> IDLE on the edge that zeroes entry DEPTH-1. busy falls with that edge.
  - Total busy duration: DEPTH-1 = 31 cycles.
- Simultaneous events:
  - clr_req together with a valid write while in IDLE: the write completes, then the clear starts and wipes it.
  - clr_req while in CLEAR: ignored, no restart.
  - we=1 while busy=1: the write is discarded silently. The source must hold off until busy=0.
- Reads during CLEAR are legal. They return 0 for entries already cleared and the old contents for entries not yet cleared.
- Reset mid-clear: aborts the clear. The array is zeroed by reset anyway, and the block returns to IDLE with busy=0.
- No X propagation: out-of-range addresses cannot occur, since DEPTH=2^AW.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- With the macro:
  - if a write is accepted this cycle (we=1, busy=0, waddr!=0) and raddr_x==waddr, then rdata_x <= wdata (write-through forwarding)
  - each port is forwarded independently
  - address 0 is never forwarded
- Without the macro: old-value semantics as in Behaviour.

Decomposition:
- Package regfile_pkg holds:
  - constants WIDTH_DEF=32, DEPTH_DEF=32, AW_DEF=5
  - enum typedef clr_state_t {IDLE, CLEAR}
  - typedef word_t = logic[WIDTH-1:0]
- One sub-module is natural: regfile_clr_fsm.
  - Holds the state register and the AW-bit counter.
  - Outputs busy, clr_we and clr_addr to the array write mux.
- Array and read registers stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then rst=1 and read all 32 addresses on A and B -> every rdata=0 and busy=0.
- Basic write/read: write 10 to address 3, 20 to 7, 30 to 31; next cycle raddr_a=3, raddr_b=7 -> rdata_a=10, rdata_b=20; then raddr_a=31 -> 30.
- Zero register: write 0xDEADBEEF to address 0, then read address 0 on both ports -> 0.
- Same-cycle RAW:
  - write 40 to address 5 while raddr_a=5, where entry 5 previously held 10
  - without REGFILE_BYPASS_EN -> rdata_a=10, and 40 on the next read
  - with REGFILE_BYPASS_EN -> rdata_a=40 immediately
- Bulk clear:
  - fill addresses 1-31 with value 10*i, then pulse clr_req
  - busy is high for exactly 31 cycles
  - a write of 99 to address 4 during busy is discarded
  - after busy falls, all entries read 0
- Reset mid-clear: pulse clr_req, assert rst=0 on the 10th busy cycle -> busy=0 at the next edge, all entries 0, and a later clr_req runs a full 31-cycle clear.
